// File: rtl/instr_loader.sv
// ============================================================================
// Module      : instr_loader
// Description : Boot loader that assembles a length-prefixed byte stream into
//               32-bit words and writes them into instruction memory; keeps
//               the core in reset until the image is complete.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 501
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_we,
  output logic [WIDTH-1:0] o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [15:0]      o_word_cnt,
  output logic             o_cpu_rst_n
);

  localparam logic [15:0] c_depth = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_BYTE   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [15:0]        r_len;
  logic [1:0]         r_byte_idx;
  logic [15:0]        r_word_idx;
  logic [15:0]        r_word_cnt;
  logic [23:0]        r_asm;
  logic [WIDTH-1:0]   r_waddr;
  logic [WIDTH-1:0]   r_wdata;

  logic               w_ready;
  logic               w_busy;
  logic               w_done;
  logic               w_error;
  logic               w_we;
  logic               w_clear;
  logic               w_xfer;
  logic [15:0]        w_len_full;
  logic               w_len_bad;
  logic               w_last_word;

  assign w_xfer      = i_rx_valid & w_ready;
  assign w_len_full  = {i_rx_data, r_len[7:0]};
  assign w_len_bad   = (w_len_full == 16'd0) || (w_len_full > c_depth);
  assign w_last_word = ((r_word_idx + 16'd1) == r_len);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_error = 1'b0;
    w_we    = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clear = 1'b1;
          w_next  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (w_xfer) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (w_xfer) w_next = w_len_bad ? S_ERROR : S_BYTE;
      end
      S_BYTE: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (w_xfer && (r_byte_idx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_we   = 1'b1;
        w_busy = 1'b1;
        w_next = w_last_word ? S_DONE : S_BYTE;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (i_start) begin
          w_clear = 1'b1;
          w_next  = S_LEN_LO;
        end
      end
      S_ERROR: begin
        w_error = 1'b1;
        if (i_start) begin
          w_clear = 1'b1;
          w_next  = S_LEN_LO;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Write address/data are captured with the lane-3 byte so they hold between writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len      <= 16'd0;
      r_byte_idx <= 2'd0;
      r_word_idx <= 16'd0;
      r_word_cnt <= 16'd0;
      r_asm      <= 24'd0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      if (w_clear) begin
        r_len      <= 16'd0;
        r_byte_idx <= 2'd0;
        r_word_idx <= 16'd0;
        r_word_cnt <= 16'd0;
      end
      if (w_xfer && (r_state == S_LEN_LO)) r_len[7:0]  <= i_rx_data;
      if (w_xfer && (r_state == S_LEN_HI)) r_len[15:8] <= i_rx_data;
      if (w_xfer && (r_state == S_BYTE)) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0: r_asm[7:0]   <= i_rx_data;
          2'd1: r_asm[15:8]  <= i_rx_data;
          2'd2: r_asm[23:16] <= i_rx_data;
          default: begin
            r_wdata <= WIDTH'({i_rx_data, r_asm});
            r_waddr <= WIDTH'({r_word_idx, 2'b00});
          end
        endcase
      end
      if (r_state == S_WRITE) begin
        r_word_idx <= r_word_idx + 16'd1;
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

  assign o_rx_ready  = w_ready;
  assign o_we        = w_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_busy      = w_busy;
  assign o_done      = w_done;
  assign o_error     = w_error;
  assign o_word_cnt  = r_word_cnt;
  assign o_cpu_rst_n = w_done;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
// Module      : tb_instr_loader
// Description : Self-checking bench for instr_loader with a stream-level model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_loader;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        o_we;
  logic [31:0] o_waddr;
  logic [31:0] o_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_word_cnt;
  logic        o_cpu_rst_n;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  acc_q[$];
  logic [63:0] wr_q[$];

  instr_loader #(.WIDTH(32), .DEPTH(501)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_word_cnt  (o_word_cnt),
    .o_cpu_rst_n (o_cpu_rst_n)
  );

  always #5 i_clk = ~i_clk;

  // Monitor: records every write pulse and every byte that the next edge accepts.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_we) wr_q.push_back({o_waddr, o_wdata});
      if (i_rx_valid && o_rx_ready) acc_q.push_back(i_rx_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic make_random(input int n);
    tx_q.delete();
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    for (int i = 0; i < n * 4; i++) tx_q.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic make_counting(input int n);
    tx_q.delete();
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    for (int k = 0; k < n; k++) begin
      tx_q.push_back(k[7:0]);
      tx_q.push_back(k[15:8]);
      tx_q.push_back(k[23:16]);
      tx_q.push_back(k[31:24]);
    end
  endtask

  task automatic drive_bytes(input int n, input int maxgap, input int start_at);
    for (int i = 0; i < n; i++) begin
      int   g;
      int   waited;
      logic rdy;
      g = $urandom_range(maxgap, 0);
      i_rx_valid = 1'b0;
      repeat (g) begin @(posedge i_clk); #1; end
      i_rx_data  = tx_q[i];
      i_rx_valid = 1'b1;
      i_start    = (i == start_at);
      waited = 0;
      rdy    = 1'b0;
      while (!rdy) begin
        @(negedge i_clk);
        rdy = o_rx_ready;
        @(posedge i_clk); #1;
        waited++;
        if (!rdy && waited > 50) begin
          check("handshake_timeout", 64'd0, 64'd1);
          rdy = 1'b1;
        end
      end
    end
    i_rx_valid = 1'b0;
    i_start    = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    check("start_busy",      o_busy,      1);
    check("start_cpu_rst_n", o_cpu_rst_n, 0);
    check("start_done",      o_done,      0);
    check("start_error",     o_error,     0);
    check("start_word_cnt",  o_word_cnt,  0);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    @(negedge i_clk);
    while (!(o_done || o_error) && t < 40) begin
      @(negedge i_clk);
      t++;
    end
    if (!(o_done || o_error)) check("session_timeout", 64'd0, 64'd1);
  endtask

  // Expected results derived purely from the stream: header, then LSB-first words.
  task automatic check_session(input string tag);
    int len;
    bit bad;
    int nacc;
    int nwr;
    logic [63:0] exp;
    len  = {tx_q[1], tx_q[0]};
    bad  = (len == 0) || (len > 501);
    nacc = (acc_q.size() < tx_q.size()) ? acc_q.size() : tx_q.size();
    check({tag, "_acc_count"}, acc_q.size(), tx_q.size());
    for (int k = 0; k < nacc; k++) check({tag, "_acc_byte"}, acc_q[k], tx_q[k]);
    if (bad) begin
      check({tag, "_wr_count"},  wr_q.size(), 0);
      check({tag, "_error"},     o_error,     1);
      check({tag, "_done"},      o_done,      0);
      check({tag, "_cpu_rst_n"}, o_cpu_rst_n, 0);
    end else begin
      nwr = (wr_q.size() < len) ? wr_q.size() : len;
      check({tag, "_wr_count"}, wr_q.size(), len);
      for (int k = 0; k < nwr; k++) begin
        exp = {32'(4 * k), tx_q[2 + 4*k + 3], tx_q[2 + 4*k + 2],
               tx_q[2 + 4*k + 1], tx_q[2 + 4*k]};
        check({tag, "_write"}, wr_q[k], exp);
      end
      check({tag, "_word_cnt"},  o_word_cnt,  len);
      check({tag, "_done"},      o_done,      1);
      check({tag, "_cpu_rst_n"}, o_cpu_rst_n, 1);
      check({tag, "_error"},     o_error,     0);
      check({tag, "_busy"},      o_busy,      0);
      check({tag, "_rx_ready"},  o_rx_ready,  0);
    end
  endtask

  task automatic run_session(input string tag, input int maxgap, input int start_at);
    acc_q.delete();
    wr_q.delete();
    pulse_start();
    drive_bytes(tx_q.size(), maxgap, start_at);
    wait_end();
    check_session(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"},  o_rx_ready,  0);
    check({tag, "_we"},        o_we,        0);
    check({tag, "_busy"},      o_busy,      0);
    check({tag, "_done"},      o_done,      0);
    check({tag, "_error"},     o_error,     0);
    check({tag, "_waddr"},     o_waddr,     0);
    check({tag, "_wdata"},     o_wdata,     0);
    check({tag, "_word_cnt"},  o_word_cnt,  0);
    check({tag, "_cpu_rst_n"}, o_cpu_rst_n, 0);
  endtask

  initial begin
    int n;
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;

    // Reset state, then 100 idle cycles without i_start
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check_reset_values("reset");
    wr_q.delete();
    repeat (100) @(posedge i_clk);
    #1;
    check("idle_wr_count",  wr_q.size(), 0);
    check("idle_rx_ready",  o_rx_ready,  0);
    check("idle_cpu_rst_n", o_cpu_rst_n, 0);

    // Known two-word image, valid held high
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_session("known", 0, -1);
    if (wr_q.size() == 2) begin
      check("known_w0", wr_q[0], 64'h00000000_00100513);
      check("known_w1", wr_q[1], 64'h00000004_00200593);
    end else begin
      check("known_w_present", wr_q.size(), 2);
    end

    // Bytes offered in DONE must not be taken
    n = acc_q.size();
    @(posedge i_clk); #1;
    i_rx_data  = 8'hAA;
    i_rx_valid = 1'b1;
    repeat (5) @(posedge i_clk);
    #1 i_rx_valid = 1'b0;
    check("done_no_accept", acc_q.size(), n);
    check("done_sticky",    o_done,       1);

    // Same image with random valid gaps
    run_session("gaps", 7, -1);

    // Illegal headers, then a valid reload
    tx_q = '{8'hF6, 8'h01};
    run_session("len502", 3, -1);
    tx_q = '{8'h00, 8'h00};
    run_session("len0", 3, -1);
    make_random(1);
    run_session("reload1", 2, -1);

    // Maximum length image, word k = k
    make_counting(501);
    run_session("max", 0, -1);
    if (wr_q.size() > 0) check("max_last", wr_q[wr_q.size() - 1], 64'h000007D0_000001F4);
    check("max_word_cnt", o_word_cnt, 501);

    // Asynchronous reset after byte 6 of a two-word image
    make_random(2);
    acc_q.delete();
    wr_q.delete();
    pulse_start();
    drive_bytes(6, 0, -1);
    #2 i_rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    run_session("after_reset", 4, -1);

    // i_start pulsed while in BYTE is ignored
    make_random(3);
    run_session("start_in_byte", 2, 5);

    // i_start from DONE writes a second image from address 0
    make_random(2);
    run_session("second_image", 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time writer for the instruction memory.
- Accepts a byte stream from a UART-RX style source over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives each word into the instruction memory write port at consecutive word-aligned byte addresses.
- Holds the CPU core in reset until the full program is written; the core then fetches from the loaded image over the normal combinational read path.

Parameters:
- WIDTH, 32, instruction word and write address width.
- DEPTH, 501, number of instruction memory words; the largest legal program length.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  begin a load session; sampled only in IDLE, DONE and ERROR.
- i_rx_data  input  8  stream byte.
- i_rx_valid  input  1  i_rx_data valid; the source holds the byte until accepted.
- o_rx_ready  output  1  loader can accept a byte this cycle.
- o_we  output  1  instruction memory write strobe, single-cycle pulse per word.
- o_waddr  output  WIDTH  byte address of the write, always word aligned (bits [1:0]=0).
- o_wdata  output  WIDTH  assembled instruction word.
- o_busy  output  1  session in progress.
- o_done  output  1  program fully written; sticky.
- o_error  output  1  illegal length header; sticky.
- o_word_cnt  output  16  number of words written in the current session.
- o_cpu_rst_n  output  1  active-low core reset; 0 until DONE.

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - o_rx_ready, o_we, o_busy, o_done and o_error are 0.
  - o_waddr, o_wdata and o_word_cnt are 0.
  - o_cpu_rst_n is 0.
  - Internal length, byte-lane and word counters are 0.
- Byte transfer: a byte is taken only on a rising edge with i_rx_valid=1 and o_rx_ready=1. Valid with ready low has no effect.
- Stream format:
  - Byte 0: length[7:0].
  - Byte 1: length[15:8].
  - Then length×4 instruction bytes, each word least-significant byte first.
- States:
  - IDLE: ready=0. If i_start=1, clear o_word_cnt, the lane index and the word index, then go to LEN_LO.
  - LEN_LO: ready=1. On a transfer, latch len[7:0] and go to LEN_HI.
  - LEN_HI: ready=1. On a transfer, latch len[15:8]. If the full length is 0 or greater than DEPTH, go to ERROR; otherwise go to BYTE.
  - BYTE: ready=1. On a transfer, place the byte into lane byte_idx (lane 0 → bits [7:0]) and increment byte_idx mod 4. After the transfer that fills lane 3, go to WRITE.
  - WRITE: ready=0. Drive o_we=1 for exactly this cycle, with o_waddr = word_idx×4 and o_wdata = the assembled word. On exit, increment word_idx and o_word_cnt. If word_idx+1 == len, go to DONE; otherwise go to BYTE.
  - DONE: ready=0, o_done=1, o_cpu_rst_n=1. Any further bytes are not accepted. If i_start=1, clear o_done, drop o_cpu_rst_n to 0 on the next cycle, clear the counters and go to LEN_LO.
  - ERROR: ready=0, o_error=1, o_cpu_rst_n=0. If i_start=1, clear o_error and the counters and go to LEN_LO.
- o_busy=1 exactly in LEN_LO, LEN_HI, BYTE and WRITE.
- i_start is ignored while busy.
- Latency and throughput:
  - o_we is asserted on the cycle after the edge that accepts the 4th byte of a word.
  - Best case is 5 cycles per word.
  - DONE is entered on the edge after the final write, so o_cpu_rst_n rises one cycle after the last o_we.
- Between writes, o_waddr and o_wdata hold the values of the last write.
- o_we is never asserted outside WRITE.
- Stalls: gaps in i_rx_valid simply extend the current state. There is no timeout.
- Addressing: word_idx never exceeds DEPTH-1 because the length is checked in LEN_HI, so o_waddr never exceeds (DEPTH-1)×4.
- Reset mid-session: the session is aborted immediately, the partial word is discarded, and the core stays in reset. Words already written remain in memory but are not marked valid.

Test Plan:
- Reset release with no i_start → IDLE: o_rx_ready=0, o_cpu_rst_n=0, no o_we for 100 cycles.
- Stream 02 00 | 13 05 10 00 | 93 05 20 00 with i_rx_valid held high:
  - o_we pulses with (o_waddr=0x0, o_wdata=0x00100513), then (o_waddr=0x4, o_wdata=0x00200593).
  - Then o_done=1, o_cpu_rst_n=1 and o_word_cnt=2.
- Same stream with random 0-7 cycle valid gaps → identical writes and final state; no byte lost or duplicated, checked against the handshake scoreboard.
- Header F6 01 (502 > DEPTH) → o_error=1 after byte 1 and no o_we. A header of 00 00 gives the same response. i_start then reloads a valid 1-word image successfully.
- Length 501 with word k = k → the last write has o_waddr=0x7D0, o_wdata=0x1F4, and o_word_cnt=501.
- i_rst_n pulsed low after byte 6 of a 2-word image → all outputs return to reset values asynchronously. A fresh i_start plus the full stream completes normally.
- i_start pulsed during BYTE → ignored.
- i_start in DONE → o_cpu_rst_n goes 0 and a second image is written from address 0.
